// File: rtl/trip_ctrl_if.sv
// Taxi trip controller bus: three raw active-low keys in, FSM state and
// datapath control strobes out.
interface trip_ctrl_if;
    logic       start_key;
    logic       wait_key;
    logic       end_key;
    logic [1:0] state;
    logic       clr;
    logic       dist_en;
    logic       wait_en;
    logic       freeze;
    logic       seg_en;
    logic [1:0] disp_sel;

    modport master (
        output start_key, wait_key, end_key,
        input  state, clr, dist_en, wait_en, freeze, seg_en, disp_sel
    );

    modport slave (
        input  start_key, wait_key, end_key,
        output state, clr, dist_en, wait_en, freeze, seg_en, disp_sel
    );
endinterface

// File: rtl/trip_ctrl.sv
// Taxi trip controller: debounces the start/wait/end keys, runs the trip
// FSM (IDLE/DRIVE/WAIT/SETTLE) and, while settling, cycles the display page
// every DISP_SEC seconds and falls back to IDLE after SETTLE_SEC seconds.
module trip_ctrl #(
    parameter logic [19:0] CNT_MAX    = 20'd999_999,
    parameter logic [25:0] Freq       = 26'd50_000_000,
    parameter int          DISP_SEC   = 3,
    parameter int          SETTLE_SEC = 30
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    trip_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } tripState_t;

    localparam logic [7:0]  DISP_LAST   = 8'(DISP_SEC - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_SEC - 1);
    localparam logic [25:0] TICK_LAST   = Freq - 26'd1;

    // Key index 0 = start, 1 = wait, 2 = end
    logic [2:0]        w_keyN;
    logic [2:0][19:0]  r_keyCnt;
    logic [2:0]        r_keyLatched;
    logic [2:0]        r_keyFlag;

    tripState_t        r_state;
    logic              r_clr;
    logic              r_distEn;
    logic              r_waitEn;
    logic              r_freeze;
    logic              r_segEn;
    logic [1:0]        r_dispSel;

    logic [25:0]       r_secTimer;
    logic [7:0]        r_secs;
    logic [7:0]        r_pageCnt;

    logic              w_startFlag;
    logic              w_waitFlag;
    logic              w_endFlag;
    logic              w_secTick;
    logic              w_timeout;
    logic              w_leaveSettle;

    assign w_keyN      = {bus.end_key, bus.wait_key, bus.start_key};
    assign w_startFlag = r_keyFlag[0];
    assign w_waitFlag  = r_keyFlag[1];
    assign w_endFlag   = r_keyFlag[2];

    assign w_secTick     = (r_state == S_SETTLE) && (r_secTimer == TICK_LAST);
    assign w_timeout     = w_secTick && (r_secs == SETTLE_LAST);
    assign w_leaveSettle = (r_state == S_SETTLE) && (w_startFlag || w_timeout);

    // Debounce: count cycles held low, fire one flag the cycle after the count saturates, re-arm only on release
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_keyCnt     <= '0;
            r_keyLatched <= '0;
            r_keyFlag    <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_keyN[k]) begin
                    r_keyCnt[k]     <= '0;
                    r_keyLatched[k] <= 1'b0;
                    r_keyFlag[k]    <= 1'b0;
                end else begin
                    if (r_keyCnt[k] != CNT_MAX) begin
                        r_keyCnt[k] <= r_keyCnt[k] + 20'd1;
                    end
                    r_keyFlag[k] <= (r_keyCnt[k] == CNT_MAX) && !r_keyLatched[k];
                    if (r_keyCnt[k] == CNT_MAX) begin
                        r_keyLatched[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // One-second prescaler, running only while settling and restarting from zero on every entry
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_secTimer <= '0;
        end else if ((r_state != S_SETTLE) || w_leaveSettle || w_secTick) begin
            r_secTimer <= '0;
        end else begin
            r_secTimer <= r_secTimer + 26'd1;
        end
    end

    // Trip FSM with registered strobes, plus the settle seconds/page bookkeeping that shares its exits
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_clr     <= 1'b0;
            r_distEn  <= 1'b0;
            r_waitEn  <= 1'b0;
            r_freeze  <= 1'b0;
            r_segEn   <= 1'b0;
            r_dispSel <= 2'd0;
            r_secs    <= 8'd0;
            r_pageCnt <= 8'd0;
        end else begin
            r_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_startFlag) begin
                        r_state  <= S_DRIVE;
                        r_clr    <= 1'b1;
                        r_distEn <= 1'b1;
                        r_segEn  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (w_endFlag) begin
                        r_state   <= S_SETTLE;
                        r_distEn  <= 1'b0;
                        r_freeze  <= 1'b1;
                        r_dispSel <= 2'd0;
                        r_secs    <= 8'd0;
                        r_pageCnt <= 8'd0;
                    end else if (w_waitFlag) begin
                        r_state  <= S_WAIT;
                        r_distEn <= 1'b0;
                        r_waitEn <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_endFlag) begin
                        r_state   <= S_SETTLE;
                        r_waitEn  <= 1'b0;
                        r_freeze  <= 1'b1;
                        r_dispSel <= 2'd0;
                        r_secs    <= 8'd0;
                        r_pageCnt <= 8'd0;
                    end else if (w_waitFlag) begin
                        r_state  <= S_DRIVE;
                        r_waitEn <= 1'b0;
                        r_distEn <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (w_startFlag) begin
                        r_state   <= S_DRIVE;
                        r_clr     <= 1'b1;
                        r_freeze  <= 1'b0;
                        r_distEn  <= 1'b1;
                        r_dispSel <= 2'd0;
                    end else if (w_timeout) begin
                        r_state   <= S_IDLE;
                        r_clr     <= 1'b1;
                        r_freeze  <= 1'b0;
                        r_segEn   <= 1'b0;
                        r_dispSel <= 2'd0;
                    end else if (w_secTick) begin
                        r_secs <= r_secs + 8'd1;
                        if (r_pageCnt == DISP_LAST) begin
                            r_pageCnt <= 8'd0;
                            r_dispSel <= (r_dispSel == 2'd2) ? 2'd0 : r_dispSel + 2'd1;
                        end else begin
                            r_pageCnt <= r_pageCnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_distEn  <= 1'b0;
                    r_waitEn  <= 1'b0;
                    r_freeze  <= 1'b0;
                    r_segEn   <= 1'b0;
                    r_dispSel <= 2'd0;
                end
            endcase
        end
    end

    assign bus.state    = r_state;
    assign bus.clr      = r_clr;
    assign bus.dist_en  = r_distEn;
    assign bus.wait_en  = r_waitEn;
    assign bus.freeze   = r_freeze;
    assign bus.seg_en   = r_segEn;
    assign bus.disp_sel = r_dispSel;

endmodule

// File: tb/tb_trip_ctrl.sv
// Bench for trip_ctrl with short timing parameters: directed scenarios plus
// random key activity, all compared against a trip-level reference model.
module tb_trip_ctrl;

    localparam logic [19:0] CNT_MAX    = 20'd9;
    localparam logic [25:0] FREQ       = 26'd20;
    localparam int          DISP_SEC   = 2;
    localparam int          SETTLE_SEC = 5;

    localparam int CM         = 9;
    localparam int PAGE_CYC   = 20 * DISP_SEC;
    localparam int SETTLE_CYC = 20 * SETTLE_SEC;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trip_ctrl_if bus ();

    trip_ctrl #(
        .CNT_MAX    (CNT_MAX),
        .Freq       (FREQ),
        .DISP_SEC   (DISP_SEC),
        .SETTLE_SEC (SETTLE_SEC)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    // Reference model: per-key run length of consecutive low samples, trip state,
    // and how many cycles the current settle phase has lasted.
    int mLow[3]  = '{0, 0, 0};
    bit mFlag[3] = '{0, 0, 0};
    int mState   = 0;
    bit mClr     = 1'b0;
    int mIdx     = 0;

    function automatic bit keyLevel(int k);
        case (k)
            0:       return bus.start_key;
            1:       return bus.wait_key;
            default: return bus.end_key;
        endcase
    endfunction

    function automatic int modelNext(int st, bit fs, bit fw, bit fe, int idx);
        case (st)
            0:       return fs ? 1 : 0;
            1:       return fe ? 3 : (fw ? 2 : 1);
            2:       return fe ? 3 : (fw ? 1 : 2);
            default: return fs ? 1 : ((idx == SETTLE_CYC - 1) ? 0 : 3);
        endcase
    endfunction

    function automatic bit isClr(int st, int nx);
        return (st == 0 && nx == 1) || (st == 3 && nx != 3);
    endfunction

    // Trip-level model advanced on every clock edge and cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mLow[k]  <= 0;
                mFlag[k] <= 1'b0;
            end
            mState <= 0;
            mClr   <= 1'b0;
            mIdx   <= 0;
        end else begin
            mState <= modelNext(mState, mFlag[0], mFlag[1], mFlag[2], mIdx);
            mClr   <= isClr(mState, modelNext(mState, mFlag[0], mFlag[1], mFlag[2], mIdx));
            mIdx   <= (mState == 3 && modelNext(mState, mFlag[0], mFlag[1], mFlag[2], mIdx) == 3) ? mIdx + 1 : 0;
            for (int k = 0; k < 3; k++) begin
                mLow[k]  <= keyLevel(k) ? 0 : ((mLow[k] > CM) ? mLow[k] : mLow[k] + 1);
                mFlag[k] <= !keyLevel(k) && (mLow[k] == CM);
            end
        end
    end

    function automatic logic [8:0] expVec();
        int disp;
        disp = (mState == 3) ? (mIdx / PAGE_CYC) % 3 : 0;
        return {2'(mState), mClr, (mState == 1), (mState == 2), (mState == 3), (mState != 0), 2'(disp)};
    endfunction

    function automatic logic [8:0] dutVec();
        return {bus.state, bus.clr, bus.dist_en, bus.wait_en, bus.freeze, bus.seg_en, bus.disp_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setKeys(input bit s, input bit w, input bit e);
        bus.start_key = s;
        bus.wait_key  = w;
        bus.end_key   = e;
    endtask

    // Pressed keys (1 = pressed) held long enough for one flag, then released
    task automatic pressKeys(input bit s, input bit w, input bit e);
        setKeys(!s, !w, !e);
        repeat (CM + 3) tick();
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        setKeys(1'b1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dutVec() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_async got %b want %b", dutVec(), 9'd0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (dutVec() !== expVec() || dutVec() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_release got %b want %b", dutVec(), expVec());
        end
    endtask

    task automatic test_start_key();
        setKeys(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= CM + 1; i++) begin
            tick();
            checks++;
            if (bus.state !== 2'd0 || dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL start_latency tick %0d got %b want %b", i, dutVec(), expVec());
            end
        end
        tick();
        checks++;
        if (dutVec() !== 9'b01_1_1_0_0_1_00 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL start_enter got %b want %b", dutVec(), 9'b01_1_1_0_0_1_00);
        end
        tick();
        checks++;
        if (bus.clr !== 1'b0 || bus.state !== 2'd1) begin
            errors++;
            $display("[TB] FAIL start_clr_pulse got clr %b state %0d want clr 0 state 1", bus.clr, bus.state);
        end
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_bounce();
        int changes;
        logic [1:0] prev;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        setKeys(1'b0, 1'b1, 1'b1);
        repeat (5) tick();
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
        setKeys(1'b0, 1'b1, 1'b1);
        repeat (CM + 1) tick();
        checks++;
        if (bus.state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL bounce_early got state %0d want 0", bus.state);
        end
        tick();
        checks++;
        if (bus.state !== 2'd1 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL bounce_start got %b want %b", dutVec(), expVec());
        end
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
        // Bouncing wait key, then held: exactly one DRIVE->WAIT move, no auto-repeat back
        changes = 0;
        prev = bus.state;
        setKeys(1'b1, 1'b0, 1'b1);
        repeat (5) tick();
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
        setKeys(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < CM + 2 + 100; i++) begin
            tick();
            if (bus.state !== prev) changes++;
            prev = bus.state;
        end
        checks++;
        if (changes != 1 || bus.state !== 2'd2) begin
            errors++;
            $display("[TB] FAIL bounce_no_repeat got %0d changes state %0d want 1 changes state 2", changes, bus.state);
        end
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_wait_toggle();
        pressKeys(1'b0, 1'b1, 1'b0);
        checks++;
        if (dutVec() !== 9'b01_0_1_0_0_1_00) begin
            errors++;
            $display("[TB] FAIL wait_to_drive got %b want %b", dutVec(), 9'b01_0_1_0_0_1_00);
        end
        pressKeys(1'b0, 1'b1, 1'b0);
        checks++;
        if (dutVec() !== 9'b10_0_0_1_0_1_00 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL drive_to_wait got %b want %b", dutVec(), 9'b10_0_0_1_0_1_00);
        end
        pressKeys(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.state !== 2'd1 || bus.dist_en !== 1'b1 || bus.wait_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_toggle_back got %b want state 1", dutVec());
        end
        // Start key is ignored while driving
        pressKeys(1'b1, 1'b0, 1'b0);
        checks++;
        if (dutVec() !== expVec() || bus.state !== 2'd1 || bus.clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_in_drive got %b want %b", dutVec(), expVec());
        end
    endtask

    task automatic test_end_priority();
        bit found;
        int lat;
        found = 1'b0;
        lat   = 0;
        setKeys(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 30 && !found; i++) begin
            tick();
            if (bus.state === 2'd3) begin
                found = 1'b1;
                lat   = i;
            end
        end
        checks++;
        if (!found || lat != CM + 2) begin
            errors++;
            $display("[TB] FAIL end_wait_same_cycle got found %0d latency %0d want 1 and %0d", found, lat, CM + 2);
        end
        checks++;
        if (dutVec() !== 9'b11_0_0_0_1_1_00 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL settle_enter got %b want %b", dutVec(), 9'b11_0_0_0_1_1_00);
        end
        setKeys(1'b1, 1'b1, 1'b1);
        for (int idx = 1; idx <= 101; idx++) begin
            tick();
            case (idx)
                39, 40, 79, 80, 99: begin
                    checks++;
                    if (bus.state !== 2'd3 || bus.disp_sel !== 2'((idx / PAGE_CYC) % 3) || dutVec() !== expVec()) begin
                        errors++;
                        $display("[TB] FAIL settle_page idx %0d got %b want disp %0d", idx, dutVec(), (idx / PAGE_CYC) % 3);
                    end
                end
                100: begin
                    checks++;
                    if (dutVec() !== 9'b00_1_0_0_0_0_00 || dutVec() !== expVec()) begin
                        errors++;
                        $display("[TB] FAIL settle_timeout got %b want %b", dutVec(), 9'b00_1_0_0_0_0_00);
                    end
                end
                101: begin
                    checks++;
                    if (dutVec() !== 9'd0) begin
                        errors++;
                        $display("[TB] FAIL timeout_clr_pulse got %b want %b", dutVec(), 9'd0);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_settle_start_race();
        bit found;
        pressKeys(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        setKeys(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 30 && !found; i++) begin
            tick();
            if (bus.state === 2'd3) found = 1'b1;
        end
        setKeys(1'b1, 1'b1, 1'b1);
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL race_settle_entry got state %0d want 3", bus.state);
        end
        repeat (89) tick();
        setKeys(1'b0, 1'b1, 1'b1);
        repeat (10) tick();
        checks++;
        if (bus.state !== 2'd3) begin
            errors++;
            $display("[TB] FAIL race_before got state %0d want 3", bus.state);
        end
        tick();
        checks++;
        if (dutVec() !== 9'b01_1_1_0_0_1_00 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL race_start_wins got %b want %b", dutVec(), 9'b01_1_1_0_0_1_00);
        end
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_async_reset();
        bit found;
        pressKeys(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.state !== 2'd2) begin
            errors++;
            $display("[TB] FAIL areset_setup got state %0d want 2", bus.state);
        end
        setKeys(1'b0, 1'b1, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (dutVec() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL areset_no_edge got %b want %b", dutVec(), 9'd0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (CM + 1) tick();
        checks++;
        if (bus.state !== 2'd0 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL areset_held_key got %b want %b", dutVec(), expVec());
        end
        tick();
        checks++;
        if (bus.state !== 2'd1 || bus.clr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_full_debounce got %b want state 1 clr 1", dutVec());
        end
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
        // Reset in the middle of a settle, then a fresh settle must time out after the full period
        setKeys(1'b1, 1'b1, 1'b0);
        repeat (CM + 3) tick();
        setKeys(1'b1, 1'b1, 1'b1);
        repeat (50) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pressKeys(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        setKeys(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 30 && !found; i++) begin
            tick();
            if (bus.state === 2'd3) found = 1'b1;
        end
        setKeys(1'b1, 1'b1, 1'b1);
        repeat (SETTLE_CYC - 1) tick();
        checks++;
        if (!found || bus.state !== 2'd3) begin
            errors++;
            $display("[TB] FAIL resettle_hold got state %0d want 3", bus.state);
        end
        tick();
        checks++;
        if (bus.state !== 2'd0 || bus.clr !== 1'b1 || dutVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL resettle_timeout got %b want %b", dutVec(), expVec());
        end
    endtask

    task automatic test_random();
        int  run[3];
        bit  lvl[3];
        int  rstLeft;
        for (int k = 0; k < 3; k++) begin
            lvl[k] = 1'b1;
            run[k] = $urandom_range(5, 60);
        end
        rstLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (run[k] == 0) begin
                    lvl[k] = !lvl[k];
                    run[k] = lvl[k] ? $urandom_range(10, 150) : $urandom_range(1, 16);
                end
                run[k]--;
            end
            setKeys(lvl[0], lvl[1], lvl[2]);
            if (rstLeft > 0) begin
                rstLeft--;
                if (rstLeft == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 799) == 0) begin
                rst_n   = 1'b0;
                rstLeft = 2;
            end
            tick();
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got %b want %b", i, dutVec(), expVec());
            end
        end
        rst_n = 1'b1;
        setKeys(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    initial begin
        test_reset();
        test_start_key();
        test_bounce();
        test_wait_toggle();
        test_end_priority();
        test_settle_start_race();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
